// File: rtl/topk_session_arbiter_pkg.sv
// Shared definitions for the top-k session arbiter: FSM encoding, default widths
// and the TLAST bit position within a requester beat.
package topk_session_arbiter_pkg;

    localparam int unsigned DEF_DATA_W = 512;
    localparam int unsigned DEF_META_W = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // TLAST rides directly above the payload in every requester beat.
    function automatic int unsigned tlast_bit(input int unsigned data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/topk_session_arbiter_if.sv
// Stream bundle between RX demux, top-k datapath and requesters; slave is the
// arbiter's view, master is the surrounding system's view.
interface topk_session_arbiter_if
    import topk_session_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned META_W = DEF_META_W
);
    logic [N_REQ*(DATA_W+1)-1:0]  req_tdata;
    logic [N_REQ*META_W-1:0]      req_meta;
    logic [N_REQ-1:0]             req_tvalid;
    logic [N_REQ-1:0]             req_tready;
    logic [META_W+DATA_W:0]       out_tdata;
    logic                         out_tvalid;
    logic                         out_tready;
    logic [DATA_W-1:0]            res_tdata;
    logic                         res_tvalid;
    logic                         res_tready;
    logic [DATA_W-1:0]            rsp_tdata;
    logic [N_REQ-1:0]             rsp_tvalid;
    logic [N_REQ-1:0]             rsp_tready;

    modport slave (
        input  req_tdata, req_meta, req_tvalid, out_tready, res_tdata, res_tvalid, rsp_tready,
        output req_tready, out_tdata, out_tvalid, res_tready, rsp_tdata, rsp_tvalid
    );

    modport master (
        output req_tdata, req_meta, req_tvalid, out_tready, res_tdata, res_tvalid, rsp_tready,
        input  req_tready, out_tdata, out_tvalid, res_tready, rsp_tdata, rsp_tvalid
    );

endinterface

// File: rtl/topk_session_arbiter_fifo.sv
// In-order tag FIFO recording which requester owns each outstanding packet,
// with an occupancy count that spans 0..2**ADDR_BITS.
module topk_session_arbiter_fifo #(
    parameter int unsigned DATA_SIZE = 2,
    parameter int unsigned ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  logic [DATA_SIZE-1:0] i_data,
    input  logic                 i_pop,
    output logic [DATA_SIZE-1:0] o_data,
    output logic                 o_empty,
    output logic                 o_full,
    output logic [ADDR_BITS:0]   o_count
);
    localparam int unsigned DEPTH = 2**ADDR_BITS;

    logic [DATA_SIZE-1:0] r_mem [DEPTH];
    logic [ADDR_BITS-1:0] r_wr, r_rd;
    logic [ADDR_BITS:0]   r_count;
    logic                 w_push_ok, w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (ADDR_BITS+1)'(DEPTH));
    assign o_data    = r_mem[r_rd];
    assign o_count   = r_count;
    assign w_pop_ok  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + 1'b1;
            if (w_pop_ok)  r_rd <= r_rd + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/topk_session_arbiter.sv
// Round-robin packet arbiter sharing the top-k datapath between N_REQ sessions;
// results are steered back to their source through an in-order tag FIFO.
module topk_session_arbiter
    import topk_session_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned META_W = DEF_META_W,
    parameter int unsigned TAG_AW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    topk_session_arbiter_if.slave bus,
    output logic [TAG_AW:0]      outstanding,
    output logic                 err_orphan
);
    localparam int unsigned GW    = $clog2(N_REQ);
    localparam int unsigned BW    = DATA_W + 1;
    localparam int unsigned TLAST = tlast_bit(DATA_W);

    state_t          r_state, w_next;
    logic [GW-1:0]   r_grant, r_rr_ptr, w_pick, w_head;
    logic [BW-1:0]   w_beat_data;
    logic [TAG_AW:0] w_count;
    logic            w_empty, w_full, w_beat, w_push, w_pop, r_err_orphan;

    function automatic logic [GW-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                              input logic [GW-1:0]    ptr);
        logic [GW-1:0] pick;
        logic          found;
        int unsigned   idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(ptr) + i) % N_REQ;
            if (!found && valid[idx]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_pick      = rr_pick(bus.req_tvalid, r_rr_ptr);
    assign w_beat_data = bus.req_tdata[r_grant*BW +: BW];
    assign w_beat      = (r_state == ST_BURST) && bus.req_tvalid[r_grant] && bus.out_tready;
    assign w_push      = w_beat && w_beat_data[TLAST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (|bus.req_tvalid && !w_full) w_next = ST_BURST;
            ST_BURST: if (w_push) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_tready = '0;
        bus.out_tvalid = 1'b0;
        bus.out_tdata  = {bus.req_meta[r_grant*META_W +: META_W], w_beat_data};
        if (r_state == ST_BURST) begin
            bus.out_tvalid          = bus.req_tvalid[r_grant];
            bus.req_tready[r_grant] = bus.out_tready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (r_state == ST_IDLE && w_next == ST_BURST) r_grant <= w_pick;
            if (w_push) r_rr_ptr <= (r_grant == GW'(N_REQ-1)) ? '0 : r_grant + 1'b1;
        end
    end

    // With no tag to steer to, a result is accepted and dropped as an orphan.
    always_comb begin
        bus.rsp_tvalid         = '0;
        bus.rsp_tvalid[w_head] = bus.res_tvalid & ~w_empty;
        bus.res_tready         = w_empty ? bus.res_tvalid : bus.rsp_tready[w_head];
    end

    assign bus.rsp_tdata = bus.res_tdata;
    assign w_pop         = bus.res_tvalid & bus.res_tready & ~w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_err_orphan <= 1'b0;
        else if (bus.res_tvalid && w_empty) r_err_orphan <= 1'b1;
    end

    assign err_orphan  = r_err_orphan;
    assign outstanding = w_count;

    topk_session_arbiter_fifo #(
        .DATA_SIZE (GW),
        .ADDR_BITS (TAG_AW)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (r_grant),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_topk_session_arbiter.sv
// Directed bench: arbitration order, grant hold, tag-FIFO full/steering,
// orphan results and asynchronous reset of the session arbiter.
module tb_topk_session_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned MW = 8;
    localparam int unsigned BW = DW + 1;

    logic       clk;
    logic       rst_n;
    logic [2:0] outstanding;
    logic       err_orphan;
    int         vecs;
    int         errs;
    int unsigned order [4];

    topk_session_arbiter_if #(.N_REQ(N), .DATA_W(DW), .META_W(MW)) bus ();

    topk_session_arbiter #(
        .N_REQ  (N),
        .DATA_W (DW),
        .META_W (MW),
        .TAG_AW (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .outstanding (outstanding),
        .err_orphan  (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int unsigned i, input logic v, input logic last,
                           input logic [DW-1:0] pay, input logic [MW-1:0] meta);
        bus.req_tvalid[i]          = v;
        bus.req_tdata[i*BW +: BW]  = {last, pay};
        bus.req_meta[i*MW +: MW]   = meta;
    endtask

    function automatic logic [MW+DW:0] exp_out(input logic [MW-1:0] m, input logic l,
                                               input logic [DW-1:0] p);
        return {m, l, p};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs = 0;
        errs = 0;
        order = '{1, 2, 3, 0};
        rst_n          = 1'b0;
        bus.req_tdata  = '0;
        bus.req_meta   = '0;
        bus.req_tvalid = '0;
        bus.out_tready = 1'b1;
        bus.res_tdata  = '0;
        bus.res_tvalid = 1'b0;
        bus.rsp_tready = '0;
        #1;
        chk("rst_out_tvalid", 64'(bus.out_tvalid), 64'd0);
        chk("rst_req_tready", 64'(bus.req_tready), 64'd0);
        chk("rst_res_tready", 64'(bus.res_tready), 64'd0);
        chk("rst_rsp_tvalid", 64'(bus.rsp_tvalid), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_err_orphan", 64'(err_orphan), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Single requester, 3-beat packet
        set_req(0, 1'b1, 1'b0, 16'hA000, 8'h11);
        #1;
        chk("p0_bubble", 64'(bus.out_tvalid), 64'd0);
        step();
        chk("p0_b1_ready", 64'(bus.req_tready), 64'h1);
        chk("p0_b1_data", 64'(bus.out_tdata), 64'(exp_out(8'h11, 1'b0, 16'hA000)));
        step();
        set_req(0, 1'b1, 1'b0, 16'hA001, 8'h11);
        #1;
        chk("p0_b2_valid", 64'(bus.out_tvalid), 64'd1);
        chk("p0_b2_data", 64'(bus.out_tdata), 64'(exp_out(8'h11, 1'b0, 16'hA001)));
        step();
        set_req(0, 1'b1, 1'b1, 16'hA002, 8'h11);
        #1;
        chk("p0_b3_data", 64'(bus.out_tdata), 64'(exp_out(8'h11, 1'b1, 16'hA002)));
        chk("p0_b3_outst", 64'(outstanding), 64'd0);
        step();
        set_req(0, 1'b0, 1'b0, 16'h0, 8'h11);
        #1;
        chk("p0_done_outst", 64'(outstanding), 64'd1);
        chk("p0_done_valid", 64'(bus.out_tvalid), 64'd0);

        // Return the result for tag 0
        bus.res_tvalid = 1'b1;
        bus.res_tdata  = 16'hBEEF;
        bus.rsp_tready = 4'hF;
        #1;
        chk("r0_rsp_tvalid", 64'(bus.rsp_tvalid), 64'h1);
        chk("r0_res_tready", 64'(bus.res_tready), 64'd1);
        chk("r0_rsp_tdata", 64'(bus.rsp_tdata), 64'hBEEF);
        step();
        bus.res_tvalid = 1'b0;
        #1;
        chk("r0_outst", 64'(outstanding), 64'd0);

        // All four valid, single-beat packets: round robin from pointer 1
        for (int unsigned i = 0; i < N; i++)
            set_req(i, 1'b1, 1'b1, 16'h0C00 + 16'(i), 8'h20 + 8'(i));
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_bubble", 64'(bus.out_tvalid), 64'd0);
            step();
            chk("rr_grant", 64'(bus.req_tready), 64'd1 << order[k]);
            chk("rr_data", 64'(bus.out_tdata),
                64'(exp_out(8'h20 + 8'(order[k]), 1'b1, 16'h0C00 + 16'(order[k]))));
            step();
        end
        chk("full_outst", 64'(outstanding), 64'd4);
        chk("full_hold_valid", 64'(bus.out_tvalid), 64'd0);
        step();
        chk("full_hold_valid2", 64'(bus.out_tvalid), 64'd0);
        chk("full_hold_ready", 64'(bus.req_tready), 64'd0);

        // One result frees a slot; the fifth packet is then granted
        bus.res_tvalid = 1'b1;
        bus.res_tdata  = 16'h5A01;
        #1;
        chk("f1_rsp_tvalid", 64'(bus.rsp_tvalid), 64'h2);
        chk("f1_res_tready", 64'(bus.res_tready), 64'd1);
        step();
        bus.res_tvalid = 1'b0;
        #1;
        chk("f1_outst", 64'(outstanding), 64'd3);
        chk("f1_bubble", 64'(bus.out_tvalid), 64'd0);
        step();
        chk("p5_grant", 64'(bus.req_tready), 64'h2);
        chk("p5_data", 64'(bus.out_tdata), 64'(exp_out(8'h21, 1'b1, 16'h0C01)));
        step();
        bus.req_tvalid = '0;
        #1;
        chk("p5_outst", 64'(outstanding), 64'd4);

        // Drain tags 2,3,0,1 with a downstream stall on the first
        bus.res_tvalid = 1'b1;
        bus.res_tdata  = 16'h5A02;
        #1;
        chk("d_rsp_2", 64'(bus.rsp_tvalid), 64'h4);
        bus.rsp_tready = 4'b1011;
        #1;
        chk("d_stall_ready", 64'(bus.res_tready), 64'd0);
        chk("d_stall_tvalid", 64'(bus.rsp_tvalid), 64'h4);
        step();
        chk("d_stall_outst", 64'(outstanding), 64'd4);
        bus.rsp_tready = 4'hF;
        #1;
        chk("d_unstall_ready", 64'(bus.res_tready), 64'd1);
        step();
        chk("d_rsp_3", 64'(bus.rsp_tvalid), 64'h8);
        chk("d_outst3", 64'(outstanding), 64'd3);
        step();
        chk("d_rsp_0", 64'(bus.rsp_tvalid), 64'h1);
        step();
        chk("d_rsp_1", 64'(bus.rsp_tvalid), 64'h2);
        step();
        bus.res_tvalid = 1'b0;
        #1;
        chk("d_outst0", 64'(outstanding), 64'd0);
        chk("d_no_orphan", 64'(err_orphan), 64'd0);

        // Orphan result with an empty tag FIFO
        bus.res_tvalid = 1'b1;
        bus.res_tdata  = 16'hDEAD;
        #1;
        chk("o_rsp_tvalid", 64'(bus.rsp_tvalid), 64'h0);
        chk("o_res_tready", 64'(bus.res_tready), 64'd1);
        step();
        bus.res_tvalid = 1'b0;
        #1;
        chk("o_err_set", 64'(err_orphan), 64'd1);
        chk("o_outst", 64'(outstanding), 64'd0);
        step();
        step();
        chk("o_err_sticky", 64'(err_orphan), 64'd1);

        // Requester 2 stalls mid-packet; requester 1 must wait for its TLAST
        set_req(2, 1'b1, 1'b0, 16'h2200, 8'h32);
        set_req(1, 1'b1, 1'b1, 16'h1100, 8'h31);
        #1;
        chk("h_bubble", 64'(bus.out_tvalid), 64'd0);
        step();
        chk("h_grant2", 64'(bus.req_tready), 64'h4);
        chk("h_data2a", 64'(bus.out_tdata), 64'(exp_out(8'h32, 1'b0, 16'h2200)));
        step();
        bus.req_tvalid[2] = 1'b0;
        #1;
        chk("h_gap_valid", 64'(bus.out_tvalid), 64'd0);
        chk("h_gap_ready", 64'(bus.req_tready), 64'h4);
        step();
        chk("h_gap_valid2", 64'(bus.out_tvalid), 64'd0);
        chk("h_gap_ready2", 64'(bus.req_tready), 64'h4);
        set_req(2, 1'b1, 1'b1, 16'h2201, 8'h32);
        #1;
        chk("h_last_valid", 64'(bus.out_tvalid), 64'd1);
        chk("h_last_data", 64'(bus.out_tdata), 64'(exp_out(8'h32, 1'b1, 16'h2201)));
        step();
        bus.req_tvalid[2] = 1'b0;
        #1;
        chk("h_idle_valid", 64'(bus.out_tvalid), 64'd0);
        chk("h_outst1", 64'(outstanding), 64'd1);
        step();
        chk("h_grant1", 64'(bus.req_tready), 64'h2);
        chk("h_data1", 64'(bus.out_tdata), 64'(exp_out(8'h31, 1'b1, 16'h1100)));
        step();
        bus.req_tvalid[1] = 1'b0;
        #1;
        chk("h_outst2", 64'(outstanding), 64'd2);

        // Asynchronous reset in the middle of a burst
        set_req(0, 1'b1, 1'b0, 16'h0A0A, 8'h40);
        #1;
        step();
        chk("x_burst_valid", 64'(bus.out_tvalid), 64'd1);
        chk("x_burst_ready", 64'(bus.req_tready), 64'h1);
        chk("x_pre_err", 64'(err_orphan), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("x_out_tvalid", 64'(bus.out_tvalid), 64'd0);
        chk("x_req_tready", 64'(bus.req_tready), 64'd0);
        chk("x_outst", 64'(outstanding), 64'd0);
        chk("x_err", 64'(err_orphan), 64'd0);
        bus.req_tvalid = '0;
        step();
        step();
        rst_n = 1'b1;

        // A late result after reset is treated as an orphan
        bus.res_tvalid = 1'b1;
        #1;
        chk("y_res_tready", 64'(bus.res_tready), 64'd1);
        step();
        bus.res_tvalid = 1'b0;
        #1;
        chk("y_err", 64'(err_orphan), 64'd1);
        chk("y_outst", 64'(outstanding), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
